// File: rtl/eth_rx_framer.sv
// RMII receive framer: locks onto preamble + SFD, forwards frame dibits with one cycle of latency.
// Optional statistics counters are enabled by defining ETH_RX_STATS_EN.
module eth_rx_framer #(
  parameter int MIN_PRE   = 24,
  parameter int MAX_BYTES = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        frame_done,
  output logic        frame_err,
  output logic [10:0] byte_count,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int PW = $clog2(MIN_PRE + 1);
  localparam int DW = $clog2(4 * MAX_BYTES + 1);
  localparam logic [DW-1:0] MAX_DIB = DW'(4 * MAX_BYTES);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]   dib_cnt_q, dib_cnt_d;
  logic            axiov_q, axiov_d;
  logic [1:0]      axiod_q, axiod_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [10:0]     byte_count_q, byte_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      dib_cnt_q    <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      dib_cnt_q    <= dib_cnt_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    dib_cnt_d    = dib_cnt_q;
    axiov_d      = 1'b0;
    axiod_d      = 2'b00;
    done_d       = 1'b0;
    err_d        = 1'b0;
    byte_count_d = byte_count_q;
    unique case (state_q)
      IDLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            state_d   = PRE;
            pre_cnt_d = PW'(1);
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        // Preamble faults report zero forwarded bytes.
        if (!crsdv) begin
          state_d      = IDLE;
          err_d        = 1'b1;
          byte_count_d = '0;
        end else if (rxd == 2'b01) begin
          if (pre_cnt_q < PW'(MIN_PRE)) pre_cnt_d = pre_cnt_q + PW'(1);
        end else if (rxd == 2'b11 && pre_cnt_q >= PW'(MIN_PRE)) begin
          state_d   = DATA;
          dib_cnt_d = '0;
        end else begin
          state_d      = DROP;
          err_d        = 1'b1;
          byte_count_d = '0;
        end
      end
      DATA: begin
        if (!crsdv) begin
          state_d      = IDLE;
          done_d       = (dib_cnt_q[1:0] == 2'b00);
          err_d        = (dib_cnt_q[1:0] != 2'b00);
          byte_count_d = 11'(dib_cnt_q >> 2);
        end else if (dib_cnt_q == MAX_DIB) begin
          state_d      = DROP;
          err_d        = 1'b1;
          byte_count_d = 11'(MAX_BYTES);
        end else begin
          axiov_d   = 1'b1;
          axiod_d   = rxd;
          dib_cnt_d = dib_cnt_q + DW'(1);
        end
      end
      DROP: begin
        if (!crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign byte_count = byte_count_q;

`ifdef ETH_RX_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Saturating counters fed by the registered pulses; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_q && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 16'hFFFF)    err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = 16'h0000;
  assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_rx_framer.sv
// Randomized bench for eth_rx_framer: each frame is described by preamble length, SFD dibit and
// payload length, and the expected forwarded dibits and end-of-frame pulse are derived from that description.
module tb_eth_rx_framer;

  localparam int MIN_PRE   = 24;
  localparam int MAX_BYTES = 1522;
  localparam int TAIL_NONE = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic        crsdv;
  logic [1:0]  rxd;
  logic        axiov;
  logic [1:0]  axiod;
  logic        frame_done;
  logic        frame_err;
  logic [10:0] byte_count;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int compared   = 0;
  int mismatched = 0;
  int edgeCnt    = 0;

  logic [1:0] obsQ[$];
  int firstValid, lastValid, doneCnt, errCnt, bothCnt, pulseEdge, pulseBc;

  eth_rx_framer #(.MIN_PRE(MIN_PRE), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov), .axiod(axiod), .frame_done(frame_done), .frame_err(frame_err),
    .byte_count(byte_count), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Collect everything the DUT emits, tagged with the edge that produced it.
  always @(negedge clk) begin
    if (axiov === 1'b1) begin
      obsQ.push_back(axiod);
      if (firstValid < 0) firstValid = edgeCnt;
      lastValid = edgeCnt;
    end
    if (frame_done === 1'b1 && frame_err === 1'b1) bothCnt++;
    if (frame_done === 1'b1) begin
      doneCnt++;
      pulseEdge = edgeCnt;
      pulseBc   = int'(byte_count);
    end
    if (frame_err === 1'b1) begin
      errCnt++;
      pulseEdge = edgeCnt;
      pulseBc   = int'(byte_count);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearMonitor();
    obsQ.delete();
    firstValid = -1;
    lastValid  = -1;
    doneCnt    = 0;
    errCnt     = 0;
    bothCnt    = 0;
    pulseEdge  = -1;
    pulseBc    = -1;
  endtask

  task automatic driveCycle(input logic c, input logic [1:0] d, output int e);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
    e = edgeCnt;
  endtask

  // Drive one crsdv burst and compare against the frame-level expectation.
  task automatic applyStimulus(input string tag, input int preLen, input int tail,
                               input int nData, input int rstAt);
    logic [1:0] data[$];
    int e, dataEdge0, endEdge, tailEdge;
    int expFwd, expDone, expErr, expBc, expPulse, diffs;
    logic [1:0] tailDibit;
    bit lockOk;
    dataEdge0 = -1;
    tailEdge  = -1;
    tailDibit = tail[1:0];
    clearMonitor();
    for (int i = 0; i < nData; i++) data.push_back(2'($urandom_range(0, 3)));
    if (rstAt >= 0 && rstAt + 1 < nData) data[rstAt + 1] = 2'b00;
    for (int i = 0; i < preLen; i++) driveCycle(1'b1, 2'b01, e);
    if (tail != TAIL_NONE) begin
      driveCycle(1'b1, tailDibit, tailEdge);
      for (int i = 0; i < nData; i++) begin
        if (i == rstAt) rst = 1'b1;
        driveCycle(1'b1, data[i], e);
        rst = 1'b0;
        if (i == 0) dataEdge0 = e;
      end
    end
    driveCycle(1'b0, 2'b00, endEdge);
    repeat (3) driveCycle(1'b0, 2'b00, e);

    lockOk   = (preLen >= MIN_PRE) && (tail == 3);
    expFwd   = 0;
    expDone  = 0;
    expErr   = 0;
    expBc    = -1;
    expPulse = -1;
    if (rstAt >= 0) begin
      expFwd = rstAt;
      expBc  = 0;
    end else if (preLen == 0) begin
      expFwd = 0;
    end else if (!lockOk) begin
      expErr   = 1;
      expPulse = (tail == TAIL_NONE) ? endEdge : tailEdge;
    end else if (nData > 4 * MAX_BYTES) begin
      expFwd   = 4 * MAX_BYTES;
      expErr   = 1;
      expBc    = MAX_BYTES;
      expPulse = dataEdge0 + 4 * MAX_BYTES;
    end else begin
      expFwd   = nData;
      expDone  = (nData % 4 == 0) ? 1 : 0;
      expErr   = 1 - expDone;
      expBc    = nData / 4;
      expPulse = endEdge;
    end

    diffs = 0;
    for (int i = 0; i < expFwd && i < obsQ.size(); i++)
      if (obsQ[i] !== data[i]) diffs++;
    checkOutput({tag, "_fwdCount"}, obsQ.size(), expFwd);
    checkOutput({tag, "_payloadDiffs"}, diffs, 0);
    checkOutput({tag, "_doneCount"}, doneCnt, expDone);
    checkOutput({tag, "_errCount"}, errCnt, expErr);
    checkOutput({tag, "_bothPulses"}, bothCnt, 0);
    if (expPulse >= 0) checkOutput({tag, "_pulseEdge"}, pulseEdge, expPulse);
    if (expBc >= 0 && expPulse >= 0) checkOutput({tag, "_pulseByteCount"}, pulseBc, expBc);
    if (expBc >= 0) checkOutput({tag, "_heldByteCount"}, int'(byte_count), expBc);
    if (expFwd > 0) begin
      checkOutput({tag, "_firstValidEdge"}, firstValid, dataEdge0);
      checkOutput({tag, "_lastValidEdge"}, lastValid, dataEdge0 + expFwd - 1);
    end
  endtask

  initial begin
    int e, r, preLen, tail, nData;
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 2'b00;
    clearMonitor();
    driveCycle(1'b0, 2'b00, e);
    driveCycle(1'b0, 2'b00, e);
    checkOutput("reset_axiov", int'(axiov), 0);
    checkOutput("reset_axiod", int'(axiod), 0);
    checkOutput("reset_done", int'(frame_done), 0);
    checkOutput("reset_err", int'(frame_err), 0);
    checkOutput("reset_byteCount", int'(byte_count), 0);
    checkOutput("reset_frameCnt", int'(frame_cnt), 0);
    checkOutput("reset_errCnt", int'(err_cnt), 0);
    rst = 1'b0;
    driveCycle(1'b0, 2'b00, e);

    applyStimulus("good64", 31, 3, 256, -1);
    applyStimulus("shortPre", 10, 3, 40, -1);
    applyStimulus("afterShort", 31, 3, 64, -1);
    applyStimulus("misaligned", 31, 3, 257, -1);
    applyStimulus("badSfd00", 30, 0, 20, -1);
    applyStimulus("badSfd10", 30, 2, 20, -1);
    applyStimulus("preOnly", 28, TAIL_NONE, 0, -1);
    applyStimulus("noPreamble", 0, 3, 30, -1);
    applyStimulus("minPre", MIN_PRE, 3, 240, -1);
    applyStimulus("oversize", 31, 3, 6400, -1);
    applyStimulus("afterOversize", 31, 3, 128, -1);
    applyStimulus("rstMid", 31, 3, 200, 100);
    applyStimulus("afterRst", 31, 3, 96, -1);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      nData = $urandom_range(4, 200);
      if (r == 0) begin
        preLen = 0;
        tail   = ($urandom_range(0, 1) == 0) ? 0 : 3;
      end else if (r <= 2) begin
        preLen = $urandom_range(1, MIN_PRE - 1);
        case ($urandom_range(0, 3))
          0:       tail = 3;
          1:       tail = TAIL_NONE;
          2:       tail = 0;
          default: tail = 2;
        endcase
      end else begin
        preLen = $urandom_range(MIN_PRE, 40);
        r = $urandom_range(0, 9);
        tail = (r == 0) ? 0 : ((r == 1) ? 2 : 3);
      end
      applyStimulus($sformatf("rand%0d", k), preLen, tail, nData, -1);
    end

    rst = 1'b1;
    driveCycle(1'b0, 2'b00, e);
    rst = 1'b0;
    driveCycle(1'b0, 2'b00, e);
    applyStimulus("stats_g1", 31, 3, 64, -1);
    applyStimulus("stats_b1", 10, 3, 16, -1);
    applyStimulus("stats_g2", 31, 3, 80, -1);
    applyStimulus("stats_b2", 31, 3, 81, -1);
    applyStimulus("stats_g3", 31, 3, 16, -1);
`ifdef ETH_RX_STATS_EN
    checkOutput("stats_frameCnt", int'(frame_cnt), 3);
    checkOutput("stats_errCnt", int'(err_cnt), 2);
`else
    checkOutput("stats_frameCnt", int'(frame_cnt), 0);
    checkOutput("stats_errCnt", int'(err_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
